// File: rtl/mul_hilo_unit.sv
// Issue/writeback controller for a pipelined 32x32 multiplier with architectural HI/LO.
// Optional signed multiply support is enabled by defining MUL_SIGNED_EN.
module mul_hilo_unit #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MUL_SIGNED_EN
  input  logic        signed_op,
`endif
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_y,
  input  logic        rd_hi,
  input  logic        rd_lo,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  logic [LATENCY-1:0] vld;
  logic [31:0]        hi;
  logic [31:0]        lo;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic [63:0]        result;

`ifdef MUL_SIGNED_EN
  logic [LATENCY-1:0] neg;

  // Multiply magnitudes; 0x80000000 negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    op_a   = (signed_op && a[31]) ? (~a + 32'd1) : a;
    op_b   = (signed_op && b[31]) ? (~b + 32'd1) : b;
    result = neg[LATENCY-1] ? (~mul_y + 64'd1) : mul_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg <= '0;
    end else begin
      neg[0] <= start & signed_op & (a[31] ^ b[31]);
      for (int i = 1; i < LATENCY; i++) neg[i] <= neg[i-1];
    end
  end
`else
  always_comb begin
    op_a   = a;
    op_b   = b;
    result = mul_y;
  end
`endif

  always_comb begin
    mul_a = (start && !rst) ? op_a : 32'd0;
    mul_b = (start && !rst) ? op_b : 32'd0;
  end

  assign busy  = |vld;
  assign stall = busy & (rd_hi | rd_lo | wr_hi | wr_lo);

  always_comb begin
    if (rd_hi)      rdata = hi;
    else if (rd_lo) rdata = lo;
    else            rdata = 32'd0;
  end

  // Writes only happen while idle, so they can never collide with a capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= '0;
      hi   <= 32'd0;
      lo   <= 32'd0;
      done <= 1'b0;
    end else begin
      vld[0] <= start;
      for (int i = 1; i < LATENCY; i++) vld[i] <= vld[i-1];
      done <= vld[LATENCY-1];
      if (vld[LATENCY-1]) begin
        {hi, lo} <= result;
      end else if (!busy) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Directed bench for mul_hilo_unit with a behavioural 2-stage multiplier model.
// Signed vectors are exercised only when MUL_SIGNED_EN is defined.
module tb_mul_hilo_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
`ifdef MUL_SIGNED_EN
  logic        signed_op;
`endif
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_y;
  logic        rd_hi;
  logic        rd_lo;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        stall;
  logic        done;

  logic [63:0] p1;
  logic [63:0] p2;

  int checks = 0;
  int errors = 0;

  mul_hilo_unit #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef MUL_SIGNED_EN
    .signed_op(signed_op),
`endif
    .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
    .rd_hi(rd_hi), .rd_lo(rd_lo), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wdata(wdata), .rdata(rdata), .busy(busy), .stall(stall), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two register stages between operands and y, unsigned multiply.
  always_ff @(posedge clk) begin
    p1 <= {32'd0, mul_a} * {32'd0, mul_b};
    p2 <= p1;
  end
  assign mul_y = p2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    rd_hi = 1'b1; rd_lo = 1'b0;
    #1;
    chk({tag, "_hi"}, {32'd0, rdata}, {32'd0, exp_hi});
    rd_hi = 1'b0; rd_lo = 1'b1;
    #1;
    chk({tag, "_lo"}, {32'd0, rdata}, {32'd0, exp_lo});
    rd_lo = 1'b0;
  endtask

  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic sop);
    start = 1'b1; a = va; b = vb;
`ifdef MUL_SIGNED_EN
    signed_op = sop;
`else
    if (sop) $display("signed operand request ignored in unsigned build");
`endif
  endtask

  task automatic idle_in();
    start = 1'b0; a = 32'd0; b = 32'd0;
`ifdef MUL_SIGNED_EN
    signed_op = 1'b0;
`endif
  endtask

  initial begin
    rst = 1'b1; idle_in();
    rd_hi = 1'b0; rd_lo = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = 32'd0;
    step(); step();
    start = 1'b1; a = 32'h11; b = 32'h22;
    #1;
    chk("rst_mul_a", {32'd0, mul_a}, 64'd0);
    step();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    read_hilo("rst", 32'd0, 32'd0);
    rst = 1'b0; idle_in();
    step();

    // 1: basic 3*5 timing
    issue(32'd3, 32'd5, 1'b0);
    #1;
    chk("t1_mul_a", {32'd0, mul_a}, 64'd3);
    chk("t1_mul_b", {32'd0, mul_b}, 64'd5);
    chk("t1_busy_c0", {63'd0, busy}, 64'd0);
    step(); idle_in(); #1;
    chk("t1_mul_a_idle", {32'd0, mul_a}, 64'd0);
    chk("t1_busy_c1", {63'd0, busy}, 64'd1);
    chk("t1_done_c1", {63'd0, done}, 64'd0);
    step();
    chk("t1_busy_c2", {63'd0, busy}, 64'd1);
    chk("t1_done_c2", {63'd0, done}, 64'd0);
    step();
    chk("t1_busy_c3", {63'd0, busy}, 64'd0);
    chk("t1_done_c3", {63'd0, done}, 64'd1);
    read_hilo("t1", 32'd0, 32'd15);
    step();
    chk("t1_done_c4", {63'd0, done}, 64'd0);

    // 2: max unsigned operands
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    step(); idle_in(); step(); step();
    chk("t2_done", {63'd0, done}, 64'd1);
    read_hilo("t2", 32'hFFFFFFFE, 32'h00000001);
    step();

    // 3: back-to-back issue
    issue(32'd2, 32'd3, 1'b0);
    step();
    issue(32'd4, 32'd5, 1'b0);
    step(); idle_in(); #1;
    chk("t3_done_c2", {63'd0, done}, 64'd0);
    step();
    rd_lo = 1'b1; #1;
    chk("t3_done_c3", {63'd0, done}, 64'd1);
    chk("t3_stall_c3", {63'd0, stall}, 64'd1);
    chk("t3_lo_c3", {32'd0, dut.lo}, 64'd6);
    rd_lo = 1'b0;
    step();
    chk("t3_done_c4", {63'd0, done}, 64'd1);
    chk("t3_busy_c4", {63'd0, busy}, 64'd0);
    read_hilo("t3", 32'd0, 32'd20);
    step();
    chk("t3_done_c5", {63'd0, done}, 64'd0);

    // 4: stalled read and write during flight
    issue(32'd7, 32'd9, 1'b0);
    step(); idle_in();
    rd_lo = 1'b1; wr_hi = 1'b1; wdata = 32'hDEADBEEF; #1;
    chk("t4_stall_c1", {63'd0, stall}, 64'd1);
    step();
    chk("t4_stall_c2", {63'd0, stall}, 64'd1);
    chk("t4_hi_c2", {32'd0, dut.hi}, 64'd0);
    step();
    chk("t4_stall_c3", {63'd0, stall}, 64'd0);
    chk("t4_rdata_c3", {32'd0, rdata}, 64'd63);
    chk("t4_hi_c3", {32'd0, dut.hi}, 64'd0);
    step();
    rd_lo = 1'b0; wr_hi = 1'b0; wdata = 32'd0;
    read_hilo("t4", 32'hDEADBEEF, 32'd63);
    step();

    // 5a: idle dual write
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hDEADBEEF;
    step();
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = 32'd0;
    read_hilo("t5_wr", 32'hDEADBEEF, 32'hDEADBEEF);

    // 5b: start with read and write in the same idle cycle
    issue(32'd2, 32'd2, 1'b0);
    rd_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h55; #1;
    chk("t5_rd_stall", {63'd0, stall}, 64'd0);
    chk("t5_rd_old", {32'd0, rdata}, 64'hDEADBEEF);
    step(); idle_in();
    rd_hi = 1'b0; wr_lo = 1'b0; wdata = 32'd0; #1;
    chk("t5_wr_lo", {32'd0, dut.lo}, 64'h55);
    step(); step();
    chk("t5_cap_done", {63'd0, done}, 64'd1);
    read_hilo("t5_cap", 32'd0, 32'd4);
    step();

    // 5c: reset mid-flight discards the product
    issue(32'd3, 32'd5, 1'b0);
    step(); idle_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_done_c2", {63'd0, done}, 64'd0);
    step();
    chk("t5_rst_done_c3", {63'd0, done}, 64'd0);
    step();
    chk("t5_rst_done_c4", {63'd0, done}, 64'd0);
    read_hilo("t5_rst", 32'd0, 32'd0);

`ifdef MUL_SIGNED_EN
    // 6: signed multiply
    step();
    issue(32'hFFFFFFFD, 32'd5, 1'b1);
    step(); idle_in(); step(); step();
    read_hilo("t6_neg", 32'hFFFFFFFF, 32'hFFFFFFF1);
    step();
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1);
    step(); idle_in(); step(); step();
    read_hilo("t6_min", 32'd0, 32'h80000000);
    step();
    issue(32'h80000000, 32'hFFFFFFFF, 1'b0);
    step(); idle_in(); step(); step();
    read_hilo("t6_uns", 32'h7FFFFFFF, 32'h80000000);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
